mux_4_1_rr_arb: RTL and testbench

Round-robin arbiter that shares one 4:1 select-mux output among four requesters. Each grant is held until the owner drops its request. The block drives the 2-bit select internally and presents the selected data word on a single output. It sits in front of the shared mux datapath and replaces static select-line driving.

---
 rtl/mux_4_1_rr_arb.sv | 189 ++++++++++++++++++
 tb/tb_mux_4_1_rr_arb.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_4_1_rr_arb.sv
// Round-robin arbiter driving the select of a shared 4:1 data mux; grant held until owner drops req.
// Latency: req sampled at edge k -> gnt/sel/vld registered after edge k; y is combinational from registered sel/vld.
// Backpressure: none; an owner keeps the mux until it releases (or MUX_4_1_RR_ARB_HOLD_LIMIT_EN forces release).
//
// Optional feature macro: MUX_4_1_RR_ARB_HOLD_LIMIT_EN
//   defined   : a hold counter forces release after MAX_HOLD cycles and pulses tmo for one cycle.
//   undefined : no counter is built, grants are held indefinitely and tmo is tied low.

module mux_4_1_rr_arb #(
   parameter int DW       = 1,
   parameter int MAX_HOLD = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    req,
   input  logic [DW-1:0] i_0,
   input  logic [DW-1:0] i_1,
   input  logic [DW-1:0] i_2,
   input  logic [DW-1:0] i_3,
   output logic [3:0]    gnt,
   output logic [1:0]    sel,
   output logic          vld,
   output logic [DW-1:0] y,
   output logic          tmo
);

   // MAX_HOLD must fit the 16-bit hold counter and allow at least two cycles of tenure.
   generate
      if (MAX_HOLD < 2 || MAX_HOLD > 65535) begin : g_bad_max_hold
         $error("mux_4_1_rr_arb: MAX_HOLD must be in 2..65535");
      end
   endgenerate

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t     state_q;
   state_t     state_d;

   logic [3:0] gnt_d;
   logic [1:0] sel_d;
   logic       vld_d;
   logic [1:0] ptr_q;
   logic [1:0] ptr_d;

   // Round-robin search helpers: requests rotated so bit 0 is the requester at ptr.
   logic [7:0] req_dbl;
   logic [3:0] req_rot;
   logic [1:0] win_off;
   logic [1:0] win;
   logic       any_req;
   logic       own_req;

`ifdef MUX_4_1_RR_ARB_HOLD_LIMIT_EN
   localparam logic [15:0] HOLD_LIM = 16'(MAX_HOLD);

   logic [15:0] hold_cnt_q;
   logic [15:0] hold_cnt_d;
   logic        limit_hit;
   logic        tmo_q;
   logic        tmo_d;
`endif

   // Find the first active requester at or after ptr, wrapping modulo 4.
   always_comb begin
      req_dbl = {req, req};
      req_rot = req_dbl[ptr_q +: 4];
      any_req = |req;
      if (req_rot[0]) begin
         win_off = 2'd0;
      end else if (req_rot[1]) begin
         win_off = 2'd1;
      end else if (req_rot[2]) begin
         win_off = 2'd2;
      end else begin
         win_off = 2'd3;
      end
      win     = ptr_q + win_off;
      own_req = req[sel];
   end

`ifdef MUX_4_1_RR_ARB_HOLD_LIMIT_EN
   // Owner has used up its tenure once the counter has reached the limit.
   always_comb begin
      limit_hit = (hold_cnt_q == HOLD_LIM);
   end
`endif

   // Next-state and next-output logic for the IDLE/BUSY arbiter.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt;
      sel_d   = sel;
      vld_d   = vld;
      ptr_d   = ptr_q;
`ifdef MUX_4_1_RR_ARB_HOLD_LIMIT_EN
      hold_cnt_d = hold_cnt_q;
      tmo_d      = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d = BUSY;
               gnt_d   = 4'b0001 << win;
               sel_d   = win;
               vld_d   = 1'b1;
               // ptr moves past the winner now, so a forced release hands over fairly.
               ptr_d   = win + 2'd1;
`ifdef MUX_4_1_RR_ARB_HOLD_LIMIT_EN
               hold_cnt_d = 16'd1;
`endif
            end
         end
         BUSY: begin
            if (!own_req) begin
               // Normal release; sel keeps its last value, arbitration resumes next edge.
               state_d = IDLE;
               gnt_d   = 4'b0000;
               vld_d   = 1'b0;
`ifdef MUX_4_1_RR_ARB_HOLD_LIMIT_EN
            end else if (limit_hit) begin
               // Owner still requesting but out of tenure: force the release.
               state_d = IDLE;
               gnt_d   = 4'b0000;
               vld_d   = 1'b0;
               tmo_d   = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + 16'd1;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            vld_d   = 1'b0;
         end
      endcase
   end

   // Arbiter state, grant and pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gnt     <= 4'b0000;
         sel     <= 2'd0;
         vld     <= 1'b0;
         ptr_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         gnt     <= gnt_d;
         sel     <= sel_d;
         vld     <= vld_d;
         ptr_q   <= ptr_d;
      end
   end

`ifdef MUX_4_1_RR_ARB_HOLD_LIMIT_EN
   // Hold counter and forced-release pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt_q <= 16'd0;
         tmo_q      <= 1'b0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
         tmo_q      <= tmo_d;
      end
   end

   assign tmo = tmo_q;
`else
   assign tmo = 1'b0;
`endif

   // Data mux driven only from registered sel/vld, so y never follows req directly.
   always_comb begin
      y = '0;
      if (vld) begin
         case (sel)
            2'd0:    y = i_0;
            2'd1:    y = i_1;
            2'd2:    y = i_2;
            default: y = i_3;
         endcase
      end
   end

endmodule

// File: tb/tb_mux_4_1_rr_arb.sv
// Bench for mux_4_1_rr_arb: directed phases plus random traffic against a queue-free reference model.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// Follows MUX_4_1_RR_ARB_HOLD_LIMIT_EN the same way as the design.

module tb_mux_4_1_rr_arb;

   localparam int DW = 8;
   localparam int MH = 4;

`ifdef MUX_4_1_RR_ARB_HOLD_LIMIT_EN
   localparam bit LIM = 1'b1;
`else
   localparam bit LIM = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    req;
   logic [DW-1:0] din [4];
   logic [3:0]    gnt;
   logic [1:0]    sel;
   logic          vld;
   logic [DW-1:0] y;
   logic          tmo;

   int total = 0;
   int bad   = 0;

   // reference model state: owner index (-1 = none), search start, last select, tenure length
   int m_own;
   int m_ptr;
   int m_sel;
   int m_held;
   bit m_tmo;

   int order_q[$];
   bit prev_vld;
   int tmo_seen;
   int own0_cycles;

   mux_4_1_rr_arb #(.DW(DW), .MAX_HOLD(MH)) dut (
      .clk (clk),
      .rst (rst),
      .req (req),
      .i_0 (din[0]),
      .i_1 (din[1]),
      .i_2 (din[2]),
      .i_3 (din[3]),
      .gnt (gnt),
      .sel (sel),
      .vld (vld),
      .y   (y),
      .tmo (tmo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_own  = -1;
      m_ptr  = 0;
      m_sel  = 0;
      m_held = 0;
      m_tmo  = 1'b0;
   endtask

   // One clock edge of the arbitration rules, applied to the req value present at the edge.
   task automatic model_step();
      m_tmo = 1'b0;
      if (m_own < 0) begin
         for (int i = 0; i < 4; i++) begin
            int c;
            c = (m_ptr + i) % 4;
            if (req[c]) begin
               m_own  = c;
               m_sel  = c;
               m_ptr  = (c + 1) % 4;
               m_held = 1;
               break;
            end
         end
      end else if (!req[m_own]) begin
         m_own = -1;
      end else if (LIM && m_held >= MH) begin
         m_own = -1;
         m_tmo = 1'b1;
      end else begin
         m_held++;
      end
   endtask

   task automatic check_all(input string tag);
      logic [3:0]    eg;
      logic [DW-1:0] ey;
      eg = (m_own >= 0) ? 4'(1 << m_own) : 4'b0000;
      ey = (m_own >= 0) ? din[m_sel] : '0;
      chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
      chk({tag, ".sel"}, 32'(sel), 32'(m_sel));
      chk({tag, ".vld"}, 32'(vld), 32'(m_own >= 0));
      chk({tag, ".y"},   32'(y),   32'(ey));
      chk({tag, ".tmo"}, 32'(tmo), 32'(m_tmo));
   endtask

   // Advance one clock: model follows the rising edge, outputs checked at the falling edge.
   task automatic cycle(input string tag);
      @(posedge clk);
      if (rst) model_reset();
      else     model_step();
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic sync_reset();
      rst = 1'b1;
      #1;
      model_reset();
      cycle("sreset");
      rst = 1'b0;
   endtask

   // Reset asserted between edges; outputs must clear without waiting for a clock.
   task automatic async_reset(input string tag);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      @(negedge clk);
      check_all({tag, ".hold"});
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      req = 4'b0000;
      for (int i = 0; i < 4; i++) din[i] = '0;
      model_reset();
      #2;
      check_all("reset");

      // single requester 2 with data 1, then drop
      @(negedge clk);
      rst    = 1'b0;
      req    = 4'b0100;
      din[2] = 8'h01;
      cycle("single.gnt");
      chk("single.gnt_exact", 32'(gnt), 32'h4);
      chk("single.sel_exact", 32'(sel), 32'd2);
      chk("single.y_exact",   32'(y),   32'd1);
      req = 4'b0000;
      cycle("single.drop");
      chk("single.vld_low", 32'(vld), 32'd0);
      chk("single.y_low",   32'(y),   32'd0);

      // owner 2 mid-grant, then asynchronous reset
      req = 4'b0100;
      cycle("mid.gnt");
      cycle("mid.hold");
      chk("mid.vld_before", 32'(vld), 32'd1);
      async_reset("mid.rst");
      chk("mid.rst_gnt", 32'(gnt), 32'd0);
      chk("mid.rst_y",   32'(y),   32'd0);

      // all four requesting; owner drops for one edge after 3 cycles of tenure
      req = 4'b1111;
      order_q.delete();
      prev_vld = 1'b0;
      for (int n = 0; n < 24; n++) begin
         cycle("rot");
         if (vld && !prev_vld) order_q.push_back(int'(sel));
         prev_vld = vld;
         if (m_own >= 0 && m_held == 3) req = 4'b1111 & ~(4'(1 << m_own));
         else                           req = 4'b1111;
      end
      total++;
      assert (order_q.size() >= 5) else begin
         bad++;
         $error("FAIL rot.count observed=%0d expected=5", order_q.size());
      end
      if (order_q.size() >= 5) begin
         chk("rot.ord0", 32'(order_q[0]), 32'd0);
         chk("rot.ord1", 32'(order_q[1]), 32'd1);
         chk("rot.ord2", 32'(order_q[2]), 32'd2);
         chk("rot.ord3", 32'(order_q[3]), 32'd3);
         chk("rot.ord4", 32'(order_q[4]), 32'd0);
      end

      // owner 1 ignores other requests; next winner is 3, skipping 0
      sync_reset();
      req = 4'b0010;
      cycle("np.gnt1");
      req = 4'b1011;
      for (int n = 0; n < 6; n++) begin
         cycle("np.hold");
         chk("np.gnt_held", 32'(gnt), 32'h2);
      end
      req = 4'b1001;
      cycle("np.release");
      cycle("np.next");
      chk("np.next_sel", 32'(sel), 32'd3);
      chk("np.next_gnt", 32'(gnt), 32'h8);

      // two constant requesters: hold-limit alternation or indefinite hold
      sync_reset();
      req = 4'b0011;
      tmo_seen    = 0;
      own0_cycles = 0;
      for (int n = 0; n < 120; n++) begin
         cycle("hold");
         if (tmo === 1'b1) tmo_seen++;
         if (gnt === 4'b0001) own0_cycles++;
      end
`ifdef MUX_4_1_RR_ARB_HOLD_LIMIT_EN
      chk("hold.tmo_pulses", 32'(tmo_seen), 32'd24);
`else
      chk("hold.tmo_pulses", 32'(tmo_seen), 32'd0);
      chk("hold.own0", 32'(own0_cycles), 32'd120);
`endif

      // random traffic with random data and occasional asynchronous reset
      sync_reset();
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 99) < 30) req = 4'($urandom_range(0, 15));
         for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
         #1;
         check_all("rnd.data");
         if ($urandom_range(0, 149) == 0) async_reset("rnd.rst");
         cycle("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop in case a wait never completes.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
